cache_victim_wbbuf: RTL and testbench

- Single-entry writeback buffer directly downstream of the cache victim/replacement selector.
- When the cache evicts a dirty victim line (way chosen by the victim one-hot), the block captures the line's tag, set and data in one cycle.
- It then drains the line to the bus as a burst of beats under a valid/ready handshake.
- It flags hazards so a refill of the same line stalls until the dirty copy has left.

---
 rtl/cache_victim_wbbuf.sv | 142 ++++++++++++++
 tb/tb_cache_victim_wbbuf.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_victim_wbbuf.sv
// cache_victim_wbbuf
// Single-entry writeback buffer that sits behind the cache victim selector.
// A dirty victim line (tag, set, data, one-hot way) is captured in one cycle.
// The line then drains to the bus as LINELEN/BEATLEN beats under valid/ready.
// While the line is held, a lookup of the same tag/set raises HazardMatch, so
// a refill of that line can be stalled until the dirty copy has left.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   Evict               cache requests eviction of the selected victim
//   VictimWay           one-hot victim way
//   VictimDirty         victim line is dirty
//   VictimTag, CacheSet tag and set index of the victim line
//   LineData            victim line data, beat 0 in the LSBs
//   EvictReady          buffer can accept a capture (buffer empty)
//   HeldWay             one-hot way of the held line, 0 when empty
//   WBValid/WBReady     bus beat handshake
//   WBAdr, WBData       beat byte address and beat data
//   WBLast              final beat of the line
//   LookupTag/LookupSet tag/set of an incoming miss or refill
//   HazardMatch         lookup hits the line held in the buffer
module cache_victim_wbbuf #(
  parameter int NUMWAYS   = 4,
  parameter int SETLEN    = 9,
  parameter int OFFSETLEN = 5,
  parameter int TAGLEN    = 18,
  parameter int LINELEN   = 256,
  parameter int BEATLEN   = 64
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                Evict,
  input  logic [NUMWAYS-1:0]                  VictimWay,
  input  logic                                VictimDirty,
  input  logic [TAGLEN-1:0]                   VictimTag,
  input  logic [SETLEN-1:0]                   CacheSet,
  input  logic [LINELEN-1:0]                  LineData,
  output logic                                EvictReady,
  output logic [NUMWAYS-1:0]                  HeldWay,
  output logic                                WBValid,
  input  logic                                WBReady,
  output logic [TAGLEN+SETLEN+OFFSETLEN-1:0]  WBAdr,
  output logic [BEATLEN-1:0]                  WBData,
  output logic                                WBLast,
  input  logic [TAGLEN-1:0]                   LookupTag,
  input  logic [SETLEN-1:0]                   LookupSet,
  output logic                                HazardMatch
);

  localparam int BEATS   = LINELEN / BEATLEN;
  localparam int BEATIDX = $clog2(BEATS);
  localparam int BYTEOFF = $clog2(BEATLEN / 8);

  typedef enum logic {
    EMPTY,
    DRAIN
  } stateT;

  stateT               state;
  stateT               nextState;
  logic [BEATIDX-1:0]  beatCnt;
  logic [NUMWAYS-1:0]  heldWayReg;
  logic [TAGLEN-1:0]   heldTag;
  logic [SETLEN-1:0]   heldSet;
  logic [LINELEN-1:0]  heldData;
  logic                capture;
  logic                xfer;
  logic                lastBeat;
  logic [OFFSETLEN-1:0] beatOffset;

  // State register; reset mid-drain simply abandons the held line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and handshake outputs. A capture needs a dirty victim with a
  // nonzero way; clean or wayless evictions leave the buffer empty. The buffer
  // only accepts in EMPTY, which forces a one-cycle bubble after each line.
  always_comb begin
    nextState  = state;
    EvictReady = 1'b0;
    WBValid    = 1'b0;
    capture    = 1'b0;
    case (state)
      EMPTY: begin
        EvictReady = 1'b1;
        if (Evict && VictimDirty && (VictimWay != '0)) begin
          capture   = 1'b1;
          nextState = DRAIN;
        end
      end
      DRAIN: begin
        WBValid = 1'b1;
        if (WBReady && lastBeat) begin
          nextState = EMPTY;
        end
      end
      default: nextState = EMPTY;
    endcase
  end

  assign lastBeat = (beatCnt == BEATIDX'(BEATS - 1));
  assign xfer     = WBValid & WBReady;

  // Beat counter: cleared on capture, advanced on each accepted beat. Its
  // width matches the beat count exactly, so it wraps after the last beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beatCnt    <= '0;
      heldWayReg <= '0;
    end else if (capture) begin
      beatCnt    <= '0;
      heldWayReg <= VictimWay;
    end else if (xfer) begin
      beatCnt    <= beatCnt + 1'b1;
    end
  end

  // Line payload needs no reset; it is only observed while in DRAIN.
  always_ff @(posedge clk) begin
    if (capture) begin
      heldTag  <= VictimTag;
      heldSet  <= CacheSet;
      heldData <= LineData;
    end
  end

  // Beat index lands just above the byte-within-beat bits of the offset.
  assign beatOffset = OFFSETLEN'(beatCnt) << BYTEOFF;

  assign WBAdr       = {heldTag, heldSet, beatOffset};
  assign WBData      = heldData[int'(beatCnt) * BEATLEN +: BEATLEN];
  assign WBLast      = WBValid & lastBeat;
  assign HeldWay     = (state == DRAIN) ? heldWayReg : '0;
  assign HazardMatch = (state == DRAIN) && (LookupTag == heldTag) &&
                       (LookupSet == heldSet);

endmodule

// File: tb/tb_cache_victim_wbbuf.sv
// Testbench for cache_victim_wbbuf: directed vectors, expected beats pushed
// into a scoreboard queue by the stimulus and popped by a separate monitor.
module tb_cache_victim_wbbuf;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         Evict;
  logic [3:0]   VictimWay;
  logic         VictimDirty;
  logic [17:0]  VictimTag;
  logic [8:0]   CacheSet;
  logic [255:0] LineData;
  logic         EvictReady;
  logic [3:0]   HeldWay;
  logic         WBValid;
  logic         WBReady;
  logic [31:0]  WBAdr;
  logic [63:0]  WBData;
  logic         WBLast;
  logic [17:0]  LookupTag;
  logic [8:0]   LookupSet;
  logic         HazardMatch;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] adr;
    logic        last;
  } beatT;

  beatT        expQ[$];
  beatT        expBeat;
  int          total = 0;
  int          bad   = 0;
  logic        stallPrev = 1'b0;
  logic [63:0] prevData;
  logic [31:0] prevAdr;

  cache_victim_wbbuf dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Evict      (Evict),
    .VictimWay  (VictimWay),
    .VictimDirty(VictimDirty),
    .VictimTag  (VictimTag),
    .CacheSet   (CacheSet),
    .LineData   (LineData),
    .EvictReady (EvictReady),
    .HeldWay    (HeldWay),
    .WBValid    (WBValid),
    .WBReady    (WBReady),
    .WBAdr      (WBAdr),
    .WBData     (WBData),
    .WBLast     (WBLast),
    .LookupTag  (LookupTag),
    .LookupSet  (LookupSet),
    .HazardMatch(HazardMatch)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] makeAdr(input logic [17:0] t, input logic [8:0] s,
                                          input logic [1:0] b);
    return {t, s, b, 3'b000};
  endfunction

  task automatic pushLine(input logic [17:0] t, input logic [8:0] s,
                          input logic [255:0] d);
    beatT e;
    for (int i = 0; i < 4; i++) begin
      e.data = d[i*64 +: 64];
      e.adr  = makeAdr(t, s, 2'(i));
      e.last = (i == 3);
      expQ.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic ev, input logic dirty, input logic [3:0] way,
                               input logic [17:0] t, input logic [8:0] s,
                               input logic [255:0] d);
    Evict       = ev;
    VictimDirty = dirty;
    VictimWay   = way;
    VictimTag   = t;
    CacheSet    = s;
    LineData    = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted beat is compared against the head of the
  // scoreboard; a stalled beat must not change until it is accepted.
  always @(negedge clk) begin
    if (!reset_n) begin
      stallPrev = 1'b0;
    end else if (WBValid) begin
      if (stallPrev) begin
        checkOutput("stallData", WBData, prevData);
        checkOutput("stallAdr", {32'd0, WBAdr}, {32'd0, prevAdr});
      end
      if (WBReady) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpectedBeat: got adr 0x%0h data 0x%0h, required no beat",
                   WBAdr, WBData);
        end else begin
          expBeat = expQ.pop_front();
          checkOutput("beatData", WBData, expBeat.data);
          checkOutput("beatAdr", {32'd0, WBAdr}, {32'd0, expBeat.adr});
          checkOutput("beatLast", {63'd0, WBLast}, {63'd0, expBeat.last});
        end
      end
      stallPrev = !WBReady;
      prevData  = WBData;
      prevAdr   = WBAdr;
    end else begin
      stallPrev = 1'b0;
    end
  end

  initial begin
    reset_n   = 1'b0;
    WBReady   = 1'b1;
    LookupTag = '0;
    LookupSet = '0;
    applyStimulus(1'b0, 1'b0, 4'b0000, '0, '0, '0);
    #2;
    checkOutput("rstEvictReady", {63'd0, EvictReady}, 64'd1);
    checkOutput("rstWBValid", {63'd0, WBValid}, 64'd0);
    checkOutput("rstWBLast", {63'd0, WBLast}, 64'd0);
    checkOutput("rstHazard", {63'd0, HazardMatch}, 64'd0);
    checkOutput("rstHeldWay", {60'd0, HeldWay}, 64'd0);
    tick;
    tick;
    reset_n = 1'b1;
    tick;

    // Full-speed capture and drain of the A/B/C/D line.
    pushLine(18'h2A5, 9'h013, {64'hD, 64'hC, 64'hB, 64'hA});
    applyStimulus(1'b1, 1'b1, 4'b0100, 18'h2A5, 9'h013, {64'hD, 64'hC, 64'hB, 64'hA});
    tick;
    applyStimulus(1'b0, 1'b0, 4'b0000, '0, '0, '0);
    LookupTag = 18'h2A5;
    LookupSet = 9'h013;
    #1;
    checkOutput("hazardHit", {63'd0, HazardMatch}, 64'd1);
    checkOutput("drainHeldWay", {60'd0, HeldWay}, 64'h4);
    checkOutput("drainEvictReady", {63'd0, EvictReady}, 64'd0);
    tick;
    LookupSet = 9'h014;
    #1;
    checkOutput("hazardOtherSet", {63'd0, HazardMatch}, 64'd0);
    LookupSet = 9'h013;
    tick;
    tick;
    checkOutput("hazardLastBeat", {63'd0, HazardMatch}, 64'd1);
    tick;
    checkOutput("doneEvictReady", {63'd0, EvictReady}, 64'd1);
    checkOutput("doneHazard", {63'd0, HazardMatch}, 64'd0);
    checkOutput("doneHeldWay", {60'd0, HeldWay}, 64'd0);
    checkOutput("doneWBValid", {63'd0, WBValid}, 64'd0);
    checkOutput("line1Drained", 64'(expQ.size()), 64'd0);

    // Clean victim and a zero victim way are both ignored.
    applyStimulus(1'b1, 1'b0, 4'b0001, 18'h111, 9'h022, {4{64'hBAD}});
    tick;
    checkOutput("cleanWBValid", {63'd0, WBValid}, 64'd0);
    checkOutput("cleanEvictReady", {63'd0, EvictReady}, 64'd1);
    applyStimulus(1'b1, 1'b1, 4'b0000, 18'h111, 9'h022, {4{64'hBAD}});
    tick;
    checkOutput("noWayWBValid", {63'd0, WBValid}, 64'd0);
    checkOutput("noWayEvictReady", {63'd0, EvictReady}, 64'd1);

    // Backpressure on beat 1, with a second dirty evict held throughout.
    pushLine(18'h155, 9'h0AA, {64'h4444_0000_0000_0003, 64'h3333_0000_0000_0002,
                               64'h2222_0000_0000_0001, 64'h1111_0000_0000_0000});
    applyStimulus(1'b1, 1'b1, 4'b1000, 18'h155, 9'h0AA,
                  {64'h4444_0000_0000_0003, 64'h3333_0000_0000_0002,
                   64'h2222_0000_0000_0001, 64'h1111_0000_0000_0000});
    tick;
    pushLine(18'h3FF, 9'h1FF, {64'hF3F3_F3F3_0000_0003, 64'hF2F2_F2F2_0000_0002,
                               64'hF1F1_F1F1_0000_0001, 64'hF0F0_F0F0_0000_0000});
    applyStimulus(1'b1, 1'b1, 4'b0001, 18'h3FF, 9'h1FF,
                  {64'hF3F3_F3F3_0000_0003, 64'hF2F2_F2F2_0000_0002,
                   64'hF1F1_F1F1_0000_0001, 64'hF0F0_F0F0_0000_0000});
    checkOutput("busyHeldWay", {60'd0, HeldWay}, 64'h8);
    tick;
    WBReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("stallEvictReady", {63'd0, EvictReady}, 64'd0);
      checkOutput("stallWBValid", {63'd0, WBValid}, 64'd1);
    end
    WBReady = 1'b1;
    tick;
    tick;
    tick;
    checkOutput("bubbleEvictReady", {63'd0, EvictReady}, 64'd1);
    checkOutput("bubbleHeldWay", {60'd0, HeldWay}, 64'd0);
    checkOutput("bubbleWBValid", {63'd0, WBValid}, 64'd0);
    tick;
    applyStimulus(1'b0, 1'b0, 4'b0000, '0, '0, '0);
    checkOutput("line3HeldWay", {60'd0, HeldWay}, 64'h1);
    checkOutput("line3EvictReady", {63'd0, EvictReady}, 64'd0);

    // Asynchronous reset after beat 1 of the third line.
    tick;
    tick;
    checkOutput("pendingBeats", 64'(expQ.size()), 64'd2);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("asyncWBValid", {63'd0, WBValid}, 64'd0);
    checkOutput("asyncHeldWay", {60'd0, HeldWay}, 64'd0);
    checkOutput("asyncEvictReady", {63'd0, EvictReady}, 64'd1);
    checkOutput("asyncWBLast", {63'd0, WBLast}, 64'd0);
    expQ.delete();
    tick;
    tick;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("postRstWBValid", {63'd0, WBValid}, 64'd0);
      checkOutput("postRstEvictReady", {63'd0, EvictReady}, 64'd1);
    end
    checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
